// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, runs a level-req / pulse-ack handshake to
// instruction memory, absorbs ID stalls in a one-entry skid and flushes on EX redirects.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Stall,
  input  logic        Redirect,
  input  logic [31:0] Redirect_PC,
  output logic        IMem_Req,
  output logic [31:0] IMem_Addr,
  input  logic        IMem_Ack,
  input  logic [31:0] IMem_Data,
  output logic [31:0] O_PC,
  output logic [31:0] O_PC4,
  output logic [31:0] O_Inst,
  output logic        O_Valid,
  output logic        IF_ID_EN
);

  typedef enum logic [1:0] {REQ, HOLD, DRAIN} state_t;

  state_t      state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic [31:0] pc_o, pc_o_nxt;
  logic [31:0] inst_o, inst_o_nxt;
  logic        o_valid, o_valid_nxt;
  logic [31:0] pc_s, pc_s_nxt;
  logic [31:0] inst_s, inst_s_nxt;
  logic        s_valid, s_valid_nxt;
  logic [31:0] drain_addr, drain_addr_nxt;
  logic        consume;
  logic        ack;

  assign IMem_Req  = ((state == REQ) || (state == DRAIN)) && !Reset;
  assign IMem_Addr = (state == DRAIN) ? drain_addr : pc;
  assign O_PC      = pc_o;
  assign O_PC4     = pc_o + 32'd4;
  assign O_Valid   = o_valid;
  assign O_Inst    = (o_valid && !Redirect) ? inst_o : NOP_INST;
  assign IF_ID_EN  = !Stall || Redirect;
  assign consume   = o_valid && !Stall && !Redirect;
  // Acks that arrive without an active request (HOLD, reset) are stale and ignored.
  assign ack       = IMem_Ack && IMem_Req;

  always_comb begin
    state_nxt      = state;
    pc_nxt         = pc;
    pc_o_nxt       = pc_o;
    inst_o_nxt     = inst_o;
    o_valid_nxt    = o_valid;
    pc_s_nxt       = pc_s;
    inst_s_nxt     = inst_s;
    s_valid_nxt    = s_valid;
    drain_addr_nxt = drain_addr;

    if (Redirect) begin
      pc_nxt      = Redirect_PC;
      o_valid_nxt = 1'b0;
      s_valid_nxt = 1'b0;
      inst_o_nxt  = NOP_INST;
      // A request still in flight must complete at its old address before refetching.
      if ((state == REQ) && !ack) begin
        state_nxt      = DRAIN;
        drain_addr_nxt = pc;
      end else if ((state == DRAIN) && !ack) begin
        state_nxt = DRAIN;
      end else begin
        state_nxt = REQ;
      end
    end else begin
      case (state)
        REQ: begin
          if (ack) begin
            pc_nxt = pc + 32'd4;
            if (!o_valid || consume) begin
              pc_o_nxt    = pc;
              inst_o_nxt  = IMem_Data;
              o_valid_nxt = 1'b1;
            end else begin
              pc_s_nxt    = pc;
              inst_s_nxt  = IMem_Data;
              s_valid_nxt = 1'b1;
              state_nxt   = HOLD;
            end
          end else if (consume) begin
            o_valid_nxt = 1'b0;
            inst_o_nxt  = NOP_INST;
          end
        end
        HOLD: begin
          if (consume) begin
            pc_o_nxt    = pc_s;
            inst_o_nxt  = inst_s;
            s_valid_nxt = 1'b0;
            state_nxt   = REQ;
          end
        end
        DRAIN: begin
          if (ack) state_nxt = REQ;
        end
        default: state_nxt = REQ;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state   <= REQ;
      pc      <= RESET_PC;
      pc_o    <= 32'h0000_0000;
      inst_o  <= NOP_INST;
      o_valid <= 1'b0;
      s_valid <= 1'b0;
    end else begin
      state   <= state_nxt;
      pc      <= pc_nxt;
      pc_o    <= pc_o_nxt;
      inst_o  <= inst_o_nxt;
      o_valid <= o_valid_nxt;
      s_valid <= s_valid_nxt;
    end
  end

  // Skid payload and drain address are qualified by state, so they need no reset.
  always_ff @(posedge Clk) begin
    pc_s       <= pc_s_nxt;
    inst_s     <= inst_s_nxt;
    drain_addr <= drain_addr_nxt;
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: variable-latency memory plus an in-order instruction-stream
// reference, driven by directed scenarios followed by randomized traffic.
module tb_if_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;
  localparam logic [31:0] KEY      = 32'hA5A5_0000;

  logic        Clk = 1'b0;
  logic        Reset, Stall, Redirect;
  logic [31:0] Redirect_PC;
  logic        IMem_Req, IMem_Ack;
  logic [31:0] IMem_Addr, IMem_Data;
  logic [31:0] O_PC, O_PC4, O_Inst;
  logic        O_Valid, IF_ID_EN;

  if_fetch_unit #(.RESET_PC(RESET_PC), .NOP_INST(NOP_INST)) dut (
    .Clk(Clk), .Reset(Reset), .Stall(Stall), .Redirect(Redirect),
    .Redirect_PC(Redirect_PC), .IMem_Req(IMem_Req), .IMem_Addr(IMem_Addr),
    .IMem_Ack(IMem_Ack), .IMem_Data(IMem_Data), .O_PC(O_PC), .O_PC4(O_PC4),
    .O_Inst(O_Inst), .O_Valid(O_Valid), .IF_ID_EN(IF_ID_EN)
  );

  always #5 Clk = ~Clk;

  // Memory model: fixed_lat >= 0 forces a latency, otherwise random 0..3 cycles.
  int          fixed_lat = 0;
  int          lat_rand = 0;
  int          lat_eff;
  int          rem = 0;
  logic        busy = 1'b0;
  logic [31:0] cap = 32'h0;
  logic        stale_inj = 1'b0;
  logic        ack_mem;

  assign lat_eff   = (fixed_lat >= 0) ? fixed_lat : lat_rand;
  assign ack_mem   = IMem_Req && (busy ? (rem == 0) : (lat_eff == 0));
  assign IMem_Ack  = ack_mem || stale_inj;
  assign IMem_Data = ack_mem ? ((busy ? cap : IMem_Addr) ^ KEY) : 32'hDEAD_BEEF;

  always @(posedge Clk) begin
    lat_rand <= int'($urandom_range(0, 3));
    if (Reset) begin
      busy <= 1'b0;
    end else if (ack_mem) begin
      busy <= 1'b0;
    end else if (!busy && IMem_Req) begin
      busy <= 1'b1;
      rem  <= lat_eff - 1;
      cap  <= IMem_Addr;
    end else if (busy) begin
      rem <= rem - 1;
    end
  end

  int          tests = 0;
  int          fails = 0;
  int          delivered = 0;
  logic [31:0] exp_pc = RESET_PC;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  // Stream model: ID must see RESET_PC, then consecutive words, restarting at each redirect target.
  task automatic model_check();
    chk("if_id_en", {31'b0, IF_ID_EN}, {31'b0, (!Stall || Redirect)});
    chk("pc4", O_PC4, O_PC + 32'd4);
    if (!O_Valid || Redirect) chk("nop_inst", O_Inst, NOP_INST);
    if (Reset) begin
      chk("req_in_reset", {31'b0, IMem_Req}, 32'd0);
    end else if (busy) begin
      chk("req_held", {31'b0, IMem_Req}, 32'd1);
      chk("addr_stable", IMem_Addr, cap);
    end
    if (Reset) begin
      exp_pc = RESET_PC;
    end else if (Redirect) begin
      exp_pc = Redirect_PC;
    end else if (O_Valid && !Stall) begin
      chk("stream_pc", O_PC, exp_pc);
      chk("stream_inst", O_Inst, exp_pc ^ KEY);
      exp_pc = exp_pc + 32'd4;
      delivered++;
    end
  endtask

  task automatic step(input logic rst, input logic stl, input logic rd, input logic [31:0] rpc);
    @(negedge Clk);
    Reset = rst; Stall = stl; Redirect = rd; Redirect_PC = rpc;
    #1;
    model_check();
  endtask

  initial begin
    int base;
    Reset = 1'b1; Stall = 1'b0; Redirect = 1'b0; Redirect_PC = 32'h0;
    repeat (2) @(posedge Clk);

    // Reset values
    step(1'b1, 1'b0, 1'b0, 32'h0);
    chk("rst_valid", {31'b0, O_Valid}, 32'd0);
    chk("rst_pc", O_PC, 32'h0);
    chk("rst_pc4", O_PC4, 32'h4);
    chk("rst_inst", O_Inst, NOP_INST);

    // Zero-wait streaming
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 1'b0, 1'b0, 32'h0);
      chk("zw_req", {31'b0, IMem_Req}, 32'd1);
      chk("zw_addr", IMem_Addr, 32'(4 * k));
      if (k > 0) begin
        chk("zw_opc", O_PC, 32'(4 * (k - 1)));
        chk("zw_opc4", O_PC4, 32'(4 * k));
        chk("zw_valid", {31'b0, O_Valid}, 32'd1);
        chk("zw_en", {31'b0, IF_ID_EN}, 32'd1);
      end
    end

    // Stall while O_PC=8 and the fetch for C completes -> C parks in the skid
    step(1'b0, 1'b1, 1'b0, 32'h0);
    chk("st_opc", O_PC, 32'h8);
    chk("st_addr", IMem_Addr, 32'hC);
    chk("st_en", {31'b0, IF_ID_EN}, 32'd0);
    step(1'b0, 1'b1, 1'b0, 32'h0);
    chk("hold_req", {31'b0, IMem_Req}, 32'd0);
    chk("hold_opc", O_PC, 32'h8);
    stale_inj = 1'b1;
    step(1'b0, 1'b1, 1'b0, 32'h0);
    chk("hold_req2", {31'b0, IMem_Req}, 32'd0);
    chk("hold_en", {31'b0, IF_ID_EN}, 32'd0);
    stale_inj = 1'b0;
    step(1'b0, 1'b0, 1'b0, 32'h0);
    chk("rel_opc", O_PC, 32'h8);
    chk("rel_req", {31'b0, IMem_Req}, 32'd0);

    // Delayed ack with redirect on the first wait cycle -> DRAIN old address
    fixed_lat = 3;
    step(1'b0, 1'b0, 1'b1, 32'h40);
    chk("skid_opc", O_PC, 32'hC);
    chk("next_addr", IMem_Addr, 32'h10);
    chk("rd_inst", O_Inst, NOP_INST);
    chk("rd_en", {31'b0, IF_ID_EN}, 32'd1);
    for (int w = 0; w < 3; w++) begin
      if (w == 2) fixed_lat = 0;
      step(1'b0, 1'b0, 1'b0, 32'h0);
      chk("drain_req", {31'b0, IMem_Req}, 32'd1);
      chk("drain_addr", IMem_Addr, 32'h10);
      chk("drain_valid", {31'b0, O_Valid}, 32'd0);
    end
    step(1'b0, 1'b0, 1'b0, 32'h0);
    chk("tgt_addr", IMem_Addr, 32'h40);
    chk("tgt_valid", {31'b0, O_Valid}, 32'd0);

    // Redirect coincident with ack and stall
    step(1'b0, 1'b1, 1'b1, 32'h80);
    chk("rsa_ack", {31'b0, IMem_Ack}, 32'd1);
    chk("rsa_opc", O_PC, 32'h40);
    chk("rsa_en", {31'b0, IF_ID_EN}, 32'd1);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    chk("rsa_valid", {31'b0, O_Valid}, 32'd0);
    chk("rsa_addr", IMem_Addr, 32'h80);

    // Reset while HOLD, memory reset alongside, stale ack injected
    step(1'b0, 1'b1, 1'b0, 32'h0);
    chk("h_opc", O_PC, 32'h80);
    step(1'b0, 1'b1, 1'b0, 32'h0);
    chk("h_req", {31'b0, IMem_Req}, 32'd0);
    fixed_lat = 2;
    stale_inj = 1'b1;
    step(1'b1, 1'b1, 1'b0, 32'h0);
    stale_inj = 1'b0;
    step(1'b0, 1'b0, 1'b0, 32'h0);
    chk("hr_req", {31'b0, IMem_Req}, 32'd1);
    chk("hr_addr", IMem_Addr, RESET_PC);
    chk("hr_valid", {31'b0, O_Valid}, 32'd0);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    chk("hr_ack", {31'b0, IMem_Ack}, 32'd1);
    fixed_lat = 0;
    step(1'b0, 1'b0, 1'b0, 32'h0);
    chk("hr_opc", O_PC, RESET_PC);
    chk("hr_addr4", IMem_Addr, RESET_PC + 32'd4);

    // Wrap-around at the top of the address space
    step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    chk("wr_addr", IMem_Addr, 32'hFFFF_FFFC);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    chk("wr_opc", O_PC, 32'hFFFF_FFFC);
    chk("wr_opc4", O_PC4, 32'h0);
    chk("wr_addr0", IMem_Addr, 32'h0);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    chk("wr_opc0", O_PC, 32'h0);

    // Randomized traffic
    fixed_lat = -1;
    base = delivered;
    for (int n = 0; n < 3000; n++) begin
      step(($urandom % 200) == 0, ($urandom % 100) < 30, ($urandom % 100) < 4,
           $urandom & 32'hFFFF_FFFC);
    end
    Reset = 1'b0; Stall = 1'b0; Redirect = 1'b0;
    chk("progress", {31'b0, (delivered - base) > 300}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Instruction-fetch stage that produces the `I_PC`, `I_PC4` and `I_Inst` values and the `EN` strobe consumed by the IF/ID pipeline register.
- Owns the PC and runs a level-request / one-cycle-ack handshake to instruction memory.
- Absorbs ID-stage stalls with a one-entry skid buffer.
- Applies branch/jump redirects from EX, flushing wrong-path fetches so a NOP bubble enters ID.

Parameters:
- `RESET_PC`, `32'h0000_0000`: PC loaded on reset.
- `NOP_INST`, `32'h0000_0000`: instruction presented when no valid fetch is held.

Ports:
- `Clk`  in  1  clock; all state updates on the rising edge.
- `Reset`  in  1  synchronous, active-high reset.
- `Stall`  in  1  hazard unit: ID cannot accept a new instruction this cycle.
- `Redirect`  in  1  one-cycle pulse from EX: control transfer taken.
- `Redirect_PC`  in  32  target PC, valid when `Redirect`=1.
- `IMem_Req`  out  1  fetch request (level).
- `IMem_Addr`  out  32  fetch address; stable while `IMem_Req`=1.
- `IMem_Ack`  in  1  one-cycle pulse: `IMem_Data` valid; may come in the same cycle `IMem_Req` rises.
- `IMem_Data`  in  32  fetched instruction.
- `O_PC`  out  32  PC of presented instruction (to `I_PC`).
- `O_PC4`  out  32  `O_PC`+4 (to `I_PC4`).
- `O_Inst`  out  32  presented instruction (to `I_Inst`).
- `O_Valid`  out  1  output slot holds a real fetched instruction.
- `IF_ID_EN`  out  1  write enable for the IF/ID register.

Behaviour:
- Internal registers:
  - `pc`: next fetch address.
  - output slot: `pc_o`, `inst_o`, `O_Valid`.
  - skid slot: `pc_s`, `inst_s`, `s_valid`.
  - state, one of REQ, HOLD, DRAIN.
- Reset (sync, highest priority):
  - `pc`=`RESET_PC`, state=REQ.
  - `O_Valid`=0, `s_valid`=0, `O_PC`=0, `O_PC4`=4, inst_o=`NOP_INST`.
  - An `IMem_Ack` arriving while `IMem_Req`=0 is ignored, including a stale ack after mid-transaction reset.
- Combinational outputs:
  - `IMem_Req` = (state==REQ || state==DRAIN) && !Reset.
  - `IMem_Addr` = `pc` in REQ, latched old address in DRAIN.
  - `O_PC4` = `O_PC`+4, modulo 2^32; 32'hFFFF_FFFC wraps to 0.
  - `O_Inst` = (`O_Valid` && !`Redirect`) ? inst_o : `NOP_INST`.
  - `IF_ID_EN` = !`Stall` || `Redirect`. Redirect overrides Stall, so a NOP bubble is written into ID.
  - consume = `O_Valid` && !`Stall` && !`Redirect`.
- REQ:
  - Ack && !Redirect: `pc`<=`pc`+4.
    - If !`O_Valid` || consume: load output slot with {`pc`, `IMem_Data`}, `O_Valid`<=1, stay REQ.
    - Else: load skid with {`pc`, `IMem_Data`}, go HOLD.
  - No Ack: if consume then `O_Valid`<=0 and inst_o<=`NOP_INST`.
- HOLD:
  - `IMem_Req`=0.
  - On consume: output slot<=skid, `s_valid`<=0, go REQ.
- DRAIN:
  - Waits for the ack of a request already issued to the old address; that data is discarded.
  - On Ack: go REQ, with `pc` already holding the redirect target.
  - `O_Valid` stays 0 throughout.
- Redirect (priority below Reset, above all else):
  - `pc`<=`Redirect_PC`, `O_Valid`<=0, `s_valid`<=0, inst_o<=`NOP_INST`.
  - Next state:
    - REQ with no Ack this cycle: DRAIN.
    - DRAIN with no Ack: stay DRAIN.
    - Otherwise: REQ, and any same-cycle Ack data is discarded.
- Latency:
  - Zero-wait memory: a request issued in cycle N is presented in cycle N+1.
  - Steady state, no stall: one instruction per cycle.
- Invariant: `s_valid`=1 implies `O_Valid`=1, and implies state==HOLD.

Test Plan:
- Reset then zero-wait memory returning `IMem_Data`=addr^32'hA5A5_0000, Stall=0 -> `IMem_Addr` 0,4,8,C on consecutive cycles; one cycle later `O_PC`=0,4,8,C, `O_PC4`=4,8,C,10, `O_Valid`=1, `IF_ID_EN`=1.
- `Stall`=1 for 3 cycles while `O_PC`=8 with an ack pending for C -> C goes to skid; state HOLD; `IMem_Req`=0; `O_PC` holds 8 and `IF_ID_EN`=0. After Stall drops -> `O_PC`=C, then the fetch for 10 issues. No address skipped or duplicated.
- Ack delayed 3 cycles, `Redirect`=1 with `Redirect_PC`=32'h40 in the first wait cycle -> `O_Inst`=`NOP_INST` and `IF_ID_EN`=1 that cycle; DRAIN holds the old `IMem_Addr` until ack; that data is dropped; next request address = 32'h40.
- `Redirect` coincident with `Ack` and with `Stall`=1 -> ack data discarded, `IF_ID_EN`=1, `O_Valid`=0 next cycle, next `IMem_Addr`=`Redirect_PC`.
- `Reset` asserted while state=HOLD with a 2-cycle ack outstanding -> next cycle `IMem_Req`=1 with `IMem_Addr`=`RESET_PC`, `O_Valid`=0; the stale ack is ignored only while `IMem_Req`=0, and the bench must keep memory in reset alongside.
- `Redirect_PC`=32'hFFFF_FFFC, zero-wait -> `O_PC4`=0 and the next fetch address is 0 (wrap-around).
